// File: rtl/spm_prog_loader.sv
// spm_prog_loader
// Loads a program image into the RISC_SPM memory through its external-write
// port, then reads the image back over address_bus/memory_bus. It flags a
// mismatch between the 8-bit modular checksums of the written bytes and the
// read-back bytes.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   start             one-cycle pulse; starts a load when idle
//   base_addr, length first address and byte count (sampled on start;
//                     length saturates to 2^AW)
//   in_valid/in_data  byte source; in_ready accepts a byte this cycle
//   memory_bus        read data from the memory, RD_LAT cycles after address
//   ext_write, address_bus, data_bus
//                     registered memory write/read interface
//   busy, done        load in progress / one-cycle completion pulse
//   chk_err           checksum mismatch, held until the next start
//   wr_sum            running checksum of the bytes written
module spm_prog_loader #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [DW-1:0] memory_bus,
  output logic          ext_write,
  output logic [AW-1:0] address_bus,
  output logic [DW-1:0] data_bus,
  output logic          busy,
  output logic          done,
  output logic          chk_err,
  output logic [DW-1:0] wr_sum
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_DRAIN, S_READ, S_CHECK} state_t;

  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   LEN_MAX  = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] ADDR_ONE = 1;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   wcnt_q, wcnt_d;   // bytes accepted
  logic [AW:0]   rcnt_q, rcnt_d;   // read addresses issued
  logic [AW:0]   scnt_q, scnt_d;   // read samples accumulated
  logic [DW-1:0] wr_sum_q, wr_sum_d;
  logic [DW-1:0] rd_sum_q, rd_sum_d;
  logic          chk_err_q, chk_err_d;
  logic          ext_write_q, ext_write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic [AW:0]   len_sat;
  logic          hs;
  logic          issue;
  logic          samp_vld;
  logic          sum_diff;

  // Any length with the top bit set is at least 2^AW, so clamp it there.
  assign len_sat  = length[AW] ? LEN_MAX : length;
  assign in_ready = (state_q == S_WRITE) && (wcnt_q < len_q);
  assign hs       = in_valid && in_ready;
  assign issue    = (state_q == S_READ) && (rcnt_q < len_q);
  assign sum_diff = (wr_sum_q != rd_sum_q);

  // Each issued read address travels down this pipe so that memory_bus is
  // sampled exactly RD_LAT cycles after the address was presented.
  generate
    if (RD_LAT == 0) begin : g_nolat
      assign samp_vld = issue;
    end else begin : g_lat
      logic [RD_LAT-1:0] vld_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_q <= '0;
        else      vld_q <= (vld_q << 1) | RD_LAT'(issue);
      end
      assign samp_vld = vld_q[RD_LAT-1];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    scnt_d      = scnt_q;
    wr_sum_d    = wr_sum_q;
    rd_sum_d    = rd_sum_q;
    chk_err_d   = chk_err_q;
    ext_write_d = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          len_d     = len_sat;
          wcnt_d    = '0;
          wr_sum_d  = '0;
          rd_sum_d  = '0;
          chk_err_d = 1'b0;
          state_d   = (len_sat == '0) ? S_CHECK : S_WRITE;
        end
      end
      S_WRITE: begin
        if (hs) begin
          ext_write_d = 1'b1;
          addr_d      = base_q + wcnt_q[AW-1:0];
          data_d      = in_data;
          wr_sum_d    = wr_sum_q + in_data;
          wcnt_d      = wcnt_q + CNT_ONE;
          if (wcnt_q == len_q - CNT_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last write is on the bus this cycle; line up the first read.
        rcnt_d  = '0;
        scnt_d  = '0;
        addr_d  = base_q;
        state_d = S_READ;
      end
      S_READ: begin
        if (issue) begin
          addr_d = addr_q + ADDR_ONE;
          rcnt_d = rcnt_q + CNT_ONE;
        end
        if (samp_vld) begin
          rd_sum_d = rd_sum_q + memory_bus;
          scnt_d   = scnt_q + CNT_ONE;
          if (scnt_q == len_q - CNT_ONE) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        chk_err_d = sum_diff;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      scnt_q      <= '0;
      wr_sum_q    <= '0;
      rd_sum_q    <= '0;
      chk_err_q   <= 1'b0;
      ext_write_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      scnt_q      <= scnt_d;
      wr_sum_q    <= wr_sum_d;
      rd_sum_q    <= rd_sum_d;
      chk_err_q   <= chk_err_d;
      ext_write_q <= ext_write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign ext_write   = ext_write_q;
  assign address_bus = addr_q;
  assign data_bus    = data_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_CHECK);
  // Visible in the done cycle itself, then held by chk_err_q.
  assign chk_err     = chk_err_q | (done & sum_diff);
  assign wr_sum      = wr_sum_q;

endmodule
